// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: shared definitions for the WS2812B receiver.
//   - rx_state_t   : line-level FSM encoding (low / high phase)
//   - DEF_*_NS     : protocol timing defaults in nanoseconds
//   - ns2cyc()     : nanoseconds -> whole core-clock cycles (floored)
//   - sat_inc16()  : 16-bit increment that sticks at all-ones
package ws2812b_pkg;

    typedef enum logic {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } rx_state_t;

    localparam int DEF_CLOCK_MHZ   = 64;
    localparam int DEF_THRESH_NS   = 600;
    localparam int DEF_MIN_HIGH_NS = 150;
    localparam int DEF_MAX_HIGH_NS = 1100;
    localparam int DEF_RESET_NS    = 50_000;

    function automatic int ns2cyc(input int mhz, input int ns);
        return (mhz * ns) / 1000;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ws2812b_rx_sync.sv
// ws2812b_rx_sync: brings the asynchronous strip line into the clk domain
// and produces single-cycle edge pulses.
//   clk  in  core clock
//   rst  in  synchronous active-high reset
//   din  in  asynchronous data line
//   rise out one-cycle pulse on a synced 0->1 transition
//   fall out one-cycle pulse on a synced 1->0 transition
module ws2812b_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic       s1, s2, prev;
    logic [1:0] warm;
    logic       en;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            warm <= 2'd0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            if (warm != 2'd2)
                warm <= warm + 2'd1;
        end
    end

    // Edges are ignored while the synchronizer still holds reset values,
    // so a level left over from before reset cannot look like a fresh edge.
    assign en   = (warm == 2'd2);
    assign rise = en &  s2 & ~prev;
    assign fall = en & ~s2 &  prev;

endmodule

// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B NRZ receiver. Measures each high pulse, decodes it
// to a bit by width, assembles 24-bit GRB words MSB-first and hands them
// to a consumer through a one-entry valid/ready buffer.
//   clk        in   core clock
//   rst        in   synchronous active-high reset
//   din        in   asynchronous strip data line
//   data_out   out  [23:0] decoded word, bit 23 received first
//   out_valid  out  data_out holds an unconsumed word
//   out_ready  in   consumer accepts when out_valid && out_ready
//   frame_end  out  one-cycle pulse on a latch gap
//   err        out  one-cycle pulse on a bad pulse width or truncated word
//   overrun    out  one-cycle pulse when a finished word is dropped
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int CLOCK_MHZ   = DEF_CLOCK_MHZ,
    parameter int THRESH_NS   = DEF_THRESH_NS,
    parameter int MIN_HIGH_NS = DEF_MIN_HIGH_NS,
    parameter int MAX_HIGH_NS = DEF_MAX_HIGH_NS,
    parameter int RESET_NS    = DEF_RESET_NS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_end,
    output logic        err,
    output logic        overrun
);

    localparam int THRESH_CYC = ns2cyc(CLOCK_MHZ, THRESH_NS);
    localparam int MIN_CYC    = ns2cyc(CLOCK_MHZ, MIN_HIGH_NS);
    localparam int MAX_CYC    = ns2cyc(CLOCK_MHZ, MAX_HIGH_NS);
    localparam int RESET_CYC  = ns2cyc(CLOCK_MHZ, RESET_NS);

    if (THRESH_CYC > 65535 || MIN_CYC > 65535 || MAX_CYC > 65535 ||
        RESET_CYC > 65535) begin : g_range_chk
        $error("ws2812b_rx: derived cycle count exceeds 16 bits");
    end

    // Widths are compared at 17 bits because width = count + 1 can reach 2^16.
    localparam logic [16:0] THRESH_W = 17'(THRESH_CYC);
    localparam logic [16:0] MIN_W    = 17'(MIN_CYC);
    localparam logic [16:0] MAX_W    = 17'(MAX_CYC);
    localparam logic [15:0] RESET_C  = 16'(RESET_CYC);

    logic        rise, fall;
    rx_state_t   state, state_nxt;
    logic [15:0] hcnt, lcnt;
    logic [4:0]  bit_cnt;
    logic [22:0] shreg;
    logic        armed;

    logic [16:0] width;
    logic        bit_val, pulse_end, width_ok, bit_ok, pulse_bad;
    logic        word_done, gap_hit, gap_err, pop;

    ws2812b_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_LOW;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOW:  if (rise) state_nxt = S_HIGH;
            S_HIGH: if (fall) state_nxt = S_LOW;
        endcase
    end

    // hcnt is cleared on the first synced-high cycle, so on the falling
    // edge it holds one less than the number of high cycles.
    assign width     = {1'b0, hcnt} + 17'd1;
    assign bit_val   = (width >= THRESH_W);
    assign width_ok  = (width >= MIN_W) && (width <= MAX_W);
    assign pulse_end = (state == S_HIGH) && fall;
    assign bit_ok    = pulse_end &&  width_ok;
    assign pulse_bad = pulse_end && !width_ok;
    assign word_done = bit_ok && (bit_cnt == 5'd23);
    // Fires on the cycle lcnt steps onto RESET_C; saturation keeps it single.
    assign gap_hit   = (state == S_LOW) && armed && (lcnt != 16'hFFFF) &&
                       (lcnt + 16'd1 == RESET_C);
    assign gap_err   = gap_hit && (bit_cnt != 5'd0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            case (state)
                S_LOW: begin
                    lcnt <= sat_inc16(lcnt);
                    if (rise) hcnt <= '0;
                end
                S_HIGH: begin
                    hcnt <= sat_inc16(hcnt);
                    if (fall) lcnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            armed     <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            frame_end <= 1'b0;
            err       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            err       <= 1'b0;
            overrun   <= 1'b0;
            frame_end <= gap_hit;
            if (pop)
                out_valid <= 1'b0;
            if (bit_ok) begin
                armed <= 1'b1;
                shreg <= {shreg[21:0], bit_val};
                if (word_done) begin
                    bit_cnt <= '0;
                    // A same-cycle pop frees the slot, so the new word wins.
                    if (!out_valid || out_ready) begin
                        data_out  <= {shreg, bit_val};
                        out_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end else if (pulse_bad || gap_err) begin
                err     <= 1'b1;
                bit_cnt <= '0;
                shreg   <= '0;
            end
            if (gap_hit)
                armed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
module tb_ws2812b_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [23:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        frame_end;
    logic        err;
    logic        overrun;

    int n_cmp = 0;
    int n_mis = 0;

    int cyc = 0;
    int n_err, n_fe, n_ovr, n_pop, n_vcyc;
    int fe_cyc, err_cyc, ov_rise_cyc, fall_cyc;
    logic [23:0] last_pop;
    logic ov_prev = 1'b0;

    ws2812b_rx dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_end (frame_end),
        .err       (err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (err) begin n_err++; err_cyc = cyc; end
            if (frame_end) begin n_fe++; fe_cyc = cyc; end
            if (overrun) n_ovr++;
            if (out_valid) n_vcyc++;
            if (out_valid && !ov_prev) ov_rise_cyc = cyc;
            if (out_valid && out_ready) begin n_pop++; last_pop = data_out; end
        end
        ov_prev = out_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_err = 0; n_fe = 0; n_ovr = 0; n_pop = 0; n_vcyc = 0;
        fe_cyc = -1; err_cyc = -2; ov_rise_cyc = -1;
        last_pop = '0;
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) tick();
        din = 1'b0;
        fall_cyc = cyc;
        repeat (lo) tick();
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(51, 29);
        else   pulse(25, 55);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        logic [23:0] tail;
        logic [23:0] w;
        din = 1'b0; out_ready = 1'b0; rst = 1'b1;
        clr();
        repeat (3) tick();

        // reset values
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_vld", 32'(out_valid), 32'h0);
        chk("rst_flags", {29'h0, frame_end, err, overrun}, 32'h0);
        rst = 1'b0;
        repeat (5) tick();

        // basic word, consumer always ready, then long idle gap
        out_ready = 1'b1;
        clr();
        send_word(24'hA5C31E);
        chk("w1_lat", 32'(ov_rise_cyc - fall_cyc), 32'd3);
        chk("w1_data", 32'(last_pop), 32'hA5C31E);
        chk("w1_pops", 32'(n_pop), 32'd1);
        chk("w1_vcyc", 32'(n_vcyc), 32'd1);
        repeat (5000 - 29) tick();
        chk("w1_err", 32'(n_err), 32'd0);
        chk("gap_fe_cnt", 32'(n_fe), 32'd1);
        chk("gap_fe_pos", 32'(fe_cyc - ov_rise_cyc), 32'd3200);
        clr();
        repeat (4000) tick();
        chk("idle_no_fe", 32'(n_fe), 32'd0);

        // overrun: two words, consumer stalled
        out_ready = 1'b0;
        clr();
        send_word(24'h123456);
        send_word(24'hFEDCBA);
        chk("ovr_data", 32'(data_out), 32'h123456);
        chk("ovr_vld", 32'(out_valid), 32'h1);
        chk("ovr_cnt", 32'(n_ovr), 32'd1);
        chk("ovr_err", 32'(n_err), 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        chk("ovr_pop", 32'(last_pop), 32'h123456);
        chk("ovr_drain", 32'(out_valid), 32'h0);
        repeat (3300) tick();

        // width boundaries: 37->0, 38->1, 9->0, 70->1, then 20 bits of ABCDE
        clr();
        pulse(37, 40);
        pulse(38, 40);
        pulse(9, 40);
        pulse(70, 40);
        tail = 24'h0ABCDE;
        for (int i = 19; i >= 0; i--) send_bit(tail[i]);
        chk("bnd_data", 32'(last_pop), 32'h5ABCDE);
        chk("bnd_err", 32'(n_err), 32'd0);

        // 8-wide pulse aborts a partial word, next word clean; 71 is an error
        clr();
        w = 24'h3C3C3C;
        for (int i = 23; i >= 19; i--) send_bit(w[i]);
        pulse(8, 40);
        chk("short_err", 32'(n_err), 32'd1);
        send_word(24'h3C3C3C);
        chk("short_next", 32'(last_pop), 32'h3C3C3C);
        pulse(71, 40);
        chk("long_err", 32'(n_err), 32'd2);
        chk("long_pops", 32'(n_pop), 32'd1);
        repeat (3300) tick();

        // truncated word at a latch gap
        clr();
        w = 24'hABC000;
        for (int i = 23; i >= 12; i--) send_bit(w[i]);
        repeat (3300) tick();
        chk("trunc_err", 32'(n_err), 32'd1);
        chk("trunc_fe", 32'(n_fe), 32'd1);
        chk("trunc_same", 32'(fe_cyc - err_cyc), 32'd0);
        chk("trunc_nov", 32'(n_vcyc), 32'd0);
        send_word(24'h0F0F0F);
        chk("trunc_next", 32'(last_pop), 32'h0F0F0F);
        chk("trunc_pops", 32'(n_pop), 32'd1);
        repeat (3300) tick();

        // reset mid-word
        clr();
        w = 24'hFFFFFF;
        for (int i = 23; i >= 14; i--) send_bit(w[i]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_vld", 32'(out_valid), 32'h0);
        repeat (5) tick();
        send_word(24'h00FF00);
        chk("mrst_data", 32'(last_pop), 32'h00FF00);
        chk("mrst_pops", 32'(n_pop), 32'd1);
        chk("mrst_err", 32'(n_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ws2812b_rx.md
# ws2812b_rx

Receiver/decoder for the single-wire WS2812B NRZ LED protocol. It samples a strip data line, classifies each high pulse as a 0 or 1 by width, and assembles 24-bit GRB words MSB-first. Words go to a consumer through a one-entry valid/ready buffer. The receiver reports frame ends (latch gaps) and protocol errors. It loops back our own ws2812b transmitter output in test/bring-up and decodes external controllers.

## Interface
- `CLOCK_MHZ`, 64: core clock frequency; all thresholds are derived from it as floor(CLOCK_MHZ*ns/1000).
- `THRESH_NS`, 600: a high width ≥ this decodes as 1; below it decodes as 0.
- `MIN_HIGH_NS`, 150: high pulses shorter than this are errors.
- `MAX_HIGH_NS`, 1100: high pulses longer than this are errors.
- `RESET_NS`, 50_000: low time that marks a frame end (latch).
- `clk`  in  1  core clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `din`  in  1  asynchronous strip data line.
- `data_out`  out  24  decoded word; bit 23 is the first received bit.
- `out_valid`  out  1  `data_out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `frame_end`  out  1  one-cycle pulse when a latch gap is detected.
- `err`  out  1  one-cycle pulse on a protocol error.
- `overrun`  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- Derived cycle counts at default parameters: THRESH=38, MIN=9, MAX=70, RESET=3200. All counts must fit in 16 bits; elaboration must fail otherwise.
- `din` passes through a 2-flop synchronizer (flops reset to 0), then into a registered edge detector.
- Edge detection is gated off for the first 2 cycles after reset release, while the synchronizer flushes.
- FSM states:
  - S_LOW (reset state): increments the saturating low counter each cycle. A rising edge clears the high counter and goes to S_HIGH.
  - S_HIGH: increments the saturating high counter each cycle. A falling edge evaluates width w = number of synced-high cycles, clears the low counter, and returns to S_LOW.
- Falling-edge evaluation:
  - If w < MIN or w > MAX: pulse `err`, clear the bit counter, discard the partial word.
  - Otherwise: shift bit (w ≥ THRESH) into the shift register LSB and increment the bit counter.
- On the 24th valid bit:
  - Clear the bit counter.
  - If the buffer is empty, or the consumer pops it in the same cycle: load the word and assert `out_valid`.
  - Otherwise: drop the new word, keep the old one, pulse `overrun`.
- `armed` flag: set by any valid bit; cleared by reset and by `frame_end`.
- When the low counter reaches exactly RESET and `armed` is set:
  - Pulse `frame_end`.
  - If the bit counter is 1..23, also pulse `err` in the same cycle, discard the partial word, and clear the bit counter.
- `frame_end` is not ordered against the buffer; a word may still be pending when it fires.
- Reset mid-operation: everything returns to reset values; any in-flight pulse is resynchronized from scratch.

## Timing
- Reset values: `data_out`=0, `out_valid`=0, `frame_end`=0, `err`=0, `overrun`=0. Internally: state S_LOW, counters 0, `armed`=0.
- Measured width equals the `din` high time in cycles for clock-synchronous stimulus.
- Latency: `out_valid` rises 3 cycles after `din` falls on bit 24 (2 sync + 1 register). `err` and `overrun` pulse in that same cycle.
- `frame_end` pulses RESET cycles after the synced falling edge, i.e. on the cycle the low count hits RESET. It pulses once per gap.
- `out_valid` deasserts the cycle after a handshake unless a new word loads in that same cycle.
- High and low counters saturate at 16'hFFFF; they never wrap.

## Structure
- Shared package `ws2812b_pkg`:
  - FSM state encoding.
  - Nanosecond-to-cycle conversion constant expression.
  - Protocol nanosecond defaults.
- Sub-module `ws2812b_rx_sync`: 2-flop synchronizer plus rise/fall pulse outputs.
- Everything else is one module.

## Test plan
- Word 0xA5C31E, driven as 25-high/55-low for 0 and 51-high/29-low for 1, with `out_ready`=1 → `out_valid` for 1 cycle with `data_out`=0xA5C31E, no `err`.
- Two back-to-back words 0x123456 and 0xFEDCBA with `out_ready`=0 → `data_out` stays 0x123456 and `overrun` pulses once at the second word's completion.
- Width boundaries:
  - 37 → 0, 38 → 1.
  - 8 and 71 → `err`.
  - 9 and 70 → accepted.
- 12 valid bits, then `din` low for 3200 cycles → `err` and `frame_end` in the same cycle, no `out_valid`. A following full word then decodes correctly.
- One word, then 5000 low cycles → exactly one `frame_end`, at low count 3200. A later idle gap with no bits → no `frame_end`.
- Assert `rst` for 1 cycle after bit 10 of a word, then send a full word 0x00FF00 → 0x00FF00 decodes with no residue.
